// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register.
//   ST_EMPTY/ST_MAIN/ST_FULL : state encodings, chosen so the state value
//                              equals the number of held entries (occ)
//   OCC_W                    : width of the occupancy output
//   stage_state_e            : FSM state type built on the encodings above
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_MAIN  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_MAIN  = ST_MAIN,
    S_FULL  = ST_FULL
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// stage_slot: one DATA_W payload register with load enable and synchronous
// clear. Clear has priority over load.
// Ports:
//   clk_i  rising-edge clock
//   clr_i  synchronous clear to zero
//   ld_i   load d_i on the next edge
//   d_i    payload to load
//   q_o    held payload
module stage_slot #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (ld_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with optional two-entry
// skid buffer, synchronous flush and bubble masking of the presented payload.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | nothing held, out_valid_o = 0            (occ 0)
// S_MAIN  | main slot holds the presented payload    (occ 1)
// S_FULL  | main presented, skid holds the next one  (occ 2)
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   upstream has a payload
//   in_ready_o   stage accepts a payload this cycle
//   in_data_i    upstream payload
//   flush_i      synchronous kill of all held payloads
//   out_valid_o  stage presents a payload
//   out_ready_i  downstream accepts this cycle
//   out_data_o   presented payload (masked while out_valid_o = 0)
//   occ_o        number of held entries
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter bit SKID_EN    = 1'b1,
  parameter bit CLR_BUBBLE = 1'b1,
  parameter int KILL_BIT   = -1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occ_o
);

  // Single-bit mask for the kill bit; stays all-zero when KILL_BIT is out of
  // range (including -1), so no out-of-range index is ever elaborated.
  function automatic logic [DATA_W-1:0] kill_mask_f();
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == KILL_BIT) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [DATA_W-1:0] KILL_MASK = kill_mask_f();

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic              in_ready;
  logic              in_xfer;
  logic              out_xfer;
  logic              out_valid;
  logic              main_ld;
  logic              skid_ld;
  logic              main_from_skid;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid_i & in_ready;
  assign out_xfer  = out_valid & out_ready_i;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_MAIN;
          main_ld = 1'b1;
        end
      end
      S_MAIN: begin
        if (in_xfer && out_xfer) begin
          main_ld = 1'b1;
        end else if (in_xfer && SKID_EN) begin
          // Without a skid slot in_ready is low here, so this path only
          // exists in the buffered build.
          state_d = S_FULL;
          skid_ld = 1'b1;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low in FULL, so only the drain can happen.
        if (out_xfer) begin
          state_d        = S_MAIN;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush wins over any transfer on the same edge; held data is only
    // invalidated, the bubble masking hides it at the output.
    if (flush_i) begin
      state_d        = S_EMPTY;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data_i;

  stage_slot #(.DATA_W(DATA_W)) u_main (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  if (SKID_EN) begin : g_skid
    logic in_ready_q;

    stage_slot #(.DATA_W(DATA_W)) u_skid (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .ld_i  (skid_ld),
      .d_i   (in_data_i),
      .q_o   (skid_q)
    );

    // Registered ready: high unless the skid slot will be occupied.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        in_ready_q <= 1'b0;
      end else begin
        in_ready_q <= (state_d != S_FULL);
      end
    end

    // The rst_i gate keeps ready low during the cycles reset is held,
    // including before the first reset edge.
    assign in_ready = in_ready_q & ~rst_i;
  end else begin : g_noskid
    assign skid_q   = '0;
    assign in_ready = (~out_valid | out_ready_i) & ~rst_i;
  end

  // Bubble masking: a bubble never carries a live kill bit (e.g. RegWrite).
  always_comb begin
    out_data_o = main_q;
    if (!out_valid) begin
      if (CLR_BUBBLE) out_data_o = '0;
      out_data_o = out_data_o & ~KILL_MASK;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign occ_o       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main DUT: DATA_W 64, skid on, CLR_BUBBLE on, no kill bit
  logic        m_rst = 1'b1, m_flush = 1'b0, m_iv = 1'b0, m_ordy = 1'b0;
  logic [63:0] m_id = '0;
  logic        m_ir, m_ov;
  logic [63:0] m_od;
  logic [1:0]  m_occ;

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(1'b1), .CLR_BUBBLE(1'b1), .KILL_BIT(-1)) dut_m (
    .clk_i(clk), .rst_i(m_rst), .in_valid_i(m_iv), .in_ready_o(m_ir), .in_data_i(m_id),
    .flush_i(m_flush), .out_valid_o(m_ov), .out_ready_i(m_ordy), .out_data_o(m_od), .occ_o(m_occ));

  // No-skid DUT: DATA_W 16
  logic        n_rst = 1'b1, n_flush = 1'b0, n_iv = 1'b0, n_ordy = 1'b0;
  logic [15:0] n_id = '0;
  logic        n_ir, n_ov;
  logic [15:0] n_od;
  logic [1:0]  n_occ;

  pipe_stage_reg #(.DATA_W(16), .SKID_EN(1'b0), .CLR_BUBBLE(1'b1), .KILL_BIT(-1)) dut_n (
    .clk_i(clk), .rst_i(n_rst), .in_valid_i(n_iv), .in_ready_o(n_ir), .in_data_i(n_id),
    .flush_i(n_flush), .out_valid_o(n_ov), .out_ready_i(n_ordy), .out_data_o(n_od), .occ_o(n_occ));

  // Kill-bit DUT: DATA_W 8, KILL_BIT 0, CLR_BUBBLE off
  logic        k_rst = 1'b1, k_flush = 1'b0, k_iv = 1'b0, k_ordy = 1'b0;
  logic [7:0]  k_id = '0;
  logic        k_ir, k_ov;
  logic [7:0]  k_od;
  logic [1:0]  k_occ;

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b1), .CLR_BUBBLE(1'b0), .KILL_BIT(0)) dut_k (
    .clk_i(clk), .rst_i(k_rst), .in_valid_i(k_iv), .in_ready_o(k_ir), .in_data_i(k_id),
    .flush_i(k_flush), .out_valid_o(k_ov), .out_ready_i(k_ordy), .out_data_o(k_od), .occ_o(k_occ));

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        ov;
    logic [63:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic flush, input logic iv, input logic [63:0] id,
                     input logic ordy, input logic ov, input logic [63:0] od,
                     input logic [1:0] occ, input logic ir);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    vecs.push_back(v);
  endtask

  initial begin
    //   rst flush iv  id        ordy | ov  od        occ ir
    // reset held two cycles with a payload offered
    add(1, 0, 1, 64'hDEAD,   0,      0, 64'h0,     0,  0);
    add(1, 0, 1, 64'hDEAD,   0,      0, 64'h0,     0,  0);
    add(0, 0, 0, 64'h0,      0,      0, 64'h0,     0,  1);
    // streaming 1..4 with out_ready high
    add(0, 0, 1, 64'h1,      1,      1, 64'h1,     1,  1);
    add(0, 0, 1, 64'h2,      1,      1, 64'h2,     1,  1);
    add(0, 0, 1, 64'h3,      1,      1, 64'h3,     1,  1);
    add(0, 0, 1, 64'h4,      1,      1, 64'h4,     1,  1);
    add(0, 0, 0, 64'h0,      1,      0, 64'h0,     0,  1);
    // backpressure: A, B held, C offered while full
    add(0, 0, 1, 64'hA,      0,      1, 64'hA,     1,  1);
    add(0, 0, 1, 64'hB,      0,      1, 64'hA,     2,  0);
    add(0, 0, 1, 64'hC,      0,      1, 64'hA,     2,  0);
    add(0, 0, 1, 64'hC,      1,      1, 64'hB,     1,  1);
    add(0, 0, 1, 64'hC,      1,      1, 64'hC,     1,  1);
    add(0, 0, 0, 64'h0,      1,      0, 64'h0,     0,  1);
    // flush while full, with 7 offered on the flush edge
    add(0, 0, 1, 64'h5,      0,      1, 64'h5,     1,  1);
    add(0, 0, 1, 64'h6,      0,      1, 64'h5,     2,  0);
    add(0, 1, 1, 64'h7,      0,      0, 64'h0,     0,  1);
    add(0, 0, 0, 64'h0,      1,      0, 64'h0,     0,  1);
    // flush overrides simultaneous in+out transfer
    add(0, 0, 1, 64'h8,      0,      1, 64'h8,     1,  1);
    add(0, 1, 1, 64'h9,      1,      0, 64'h0,     0,  1);
    // out_ready in EMPTY has no effect
    add(0, 0, 0, 64'h0,      1,      0, 64'h0,     0,  1);
    // reset mid-stall drops held data
    add(0, 0, 1, 64'h11,     0,      1, 64'h11,    1,  1);
    add(0, 0, 1, 64'h22,     0,      1, 64'h11,    2,  0);
    add(1, 0, 1, 64'h33,     0,      0, 64'h0,     0,  0);
    add(0, 0, 0, 64'h0,      0,      0, 64'h0,     0,  1);
    add(0, 0, 1, 64'h33,     1,      1, 64'h33,    1,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      m_rst = vecs[i].rst; m_flush = vecs[i].flush; m_iv = vecs[i].iv;
      m_id = vecs[i].id;   m_ordy = vecs[i].ordy;
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 64'(m_ov),  64'(vecs[i].ov));
      check($sformatf("v%0d out_data", i),  m_od,       vecs[i].od);
      check($sformatf("v%0d occ", i),       64'(m_occ), 64'(vecs[i].occ));
      check($sformatf("v%0d in_ready", i),  64'(m_ir),  64'(vecs[i].ir));
    end
    @(negedge clk);
    m_iv = 1'b0; m_ordy = 1'b0;

    // No-skid build: combinational in_ready
    @(negedge clk);
    n_rst = 1'b1; n_iv = 1'b1; n_id = 16'hDEAD; n_ordy = 1'b0;
    @(posedge clk); #1;
    check("ns rst out_valid", 64'(n_ov), 64'(0));
    check("ns rst in_ready",  64'(n_ir), 64'(0));
    check("ns rst out_data",  64'(n_od), 64'(0));
    @(negedge clk);
    n_rst = 1'b0; n_id = 16'h1234;
    #1 check("ns empty in_ready", 64'(n_ir), 64'(1));
    @(posedge clk); #1;
    check("ns load out_valid", 64'(n_ov), 64'(1));
    check("ns load out_data",  64'(n_od), 64'h1234);
    check("ns load occ",       64'(n_occ), 64'(1));
    check("ns stall in_ready", 64'(n_ir), 64'(0));
    @(negedge clk);
    n_id = 16'h5678;
    @(posedge clk); #1;
    check("ns stall out_data", 64'(n_od), 64'h1234);
    check("ns stall in_ready2", 64'(n_ir), 64'(0));
    @(negedge clk);
    n_ordy = 1'b1;
    #1 check("ns release in_ready", 64'(n_ir), 64'(1));
    @(posedge clk); #1;
    check("ns next out_data",  64'(n_od), 64'h5678);
    check("ns next out_valid", 64'(n_ov), 64'(1));
    @(negedge clk);
    n_iv = 1'b0;
    @(posedge clk); #1;
    check("ns drain out_valid", 64'(n_ov), 64'(0));
    check("ns drain out_data",  64'(n_od), 64'(0));
    check("ns drain occ",       64'(n_occ), 64'(0));

    // Kill-bit build: bubble keeps stale data except the kill bit
    @(negedge clk);
    k_rst = 1'b1; k_iv = 1'b1; k_id = 8'hFF;
    @(posedge clk); #1;
    check("kb rst out_data",  64'(k_od), 64'(0));
    check("kb rst out_valid", 64'(k_ov), 64'(0));
    @(negedge clk);
    k_rst = 1'b0; k_iv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    k_iv = 1'b1; k_id = 8'hFF; k_ordy = 1'b0;
    @(posedge clk); #1;
    check("kb load out_valid", 64'(k_ov), 64'(1));
    check("kb load out_data",  64'(k_od), 64'hFF);
    @(negedge clk);
    k_iv = 1'b0; k_ordy = 1'b1;
    @(posedge clk); #1;
    check("kb bubble out_valid", 64'(k_ov), 64'(0));
    check("kb bubble out_data",  64'(k_od), 64'hFE);
    check("kb bubble occ",       64'(k_occ), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. It is the next generation of the fixed-field MEM/WB latch.
- Carries an opaque payload of DATA_W bits with valid/ready flow control, synchronous flush and an optional 2-entry skid buffer.
- Replaces the plain stage latches between IF/ID/EX/MEM/WB, so the core can stall and flush per stage without global enables.

Parameters:
- DATA_W, 64, payload width in bits (>=1)
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
- CLR_BUBBLE, 1, 1 = out_data is forced to 0 whenever out_valid = 0; 0 = out_data holds its last value
- KILL_BIT, -1, payload bit index (e.g. RegWrite) cleared on an output bubble when >=0; ignored when -1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has a payload
- in_ready  output  1  stage can accept a payload this cycle
- in_data  input  DATA_W  upstream payload
- flush  input  1  synchronous kill of all held payloads
- out_valid  output  1  stage presents a payload
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  presented payload
- occ  output  2  number of entries held (0..2; max 1 when SKID_EN = 0)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. On a clk edge with rst = 1:
  - out_valid = 0, out_data = 0, occ = 0, all internal valids = 0.
  - in_ready is 0 while rst = 1, in both modes.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready at the edge.
  - An output transfer occurs when out_valid & out_ready.
  - out_data and out_valid are stable while out_valid & ~out_ready; the data may not change until the transfer occurs.
- SKID_EN = 0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Latency 1 cycle. Sustains 1 payload/cycle.
- SKID_EN = 1: states EMPTY (occ 0), MAIN (occ 1), FULL (occ 2: main + skid); in_ready = ~skid_valid, registered.
  - EMPTY, input transfer -> MAIN; main <= in_data.
  - MAIN:
    - input and output transfer -> MAIN; main <= in_data.
    - input, no output -> FULL; skid <= in_data.
    - output, no input -> EMPTY.
  - FULL:
    - output transfer -> MAIN; main <= skid. No input is possible, since in_ready = 0.
  - Latency in_valid -> out_valid is 1 cycle. Full throughput with out_ready held high.
  - Order is strictly FIFO; no payload is dropped or duplicated.
- Flush:
  - Any edge with flush = 1 (rst = 0) -> EMPTY, occ = 0, out_valid = 0.
  - A payload presented on the same edge is discarded.
  - in_ready is not gated by flush.
  - Flush overrides simultaneous transfers; rst overrides flush.
- Bubble outputs:
  - CLR_BUBBLE = 1: out_data = 0 whenever out_valid = 0.
  - KILL_BIT >= 0: out_data[KILL_BIT] = 0 whenever out_valid = 0, regardless of CLR_BUBBLE.
  - Purpose: a bubble never writes the register file.
- Boundaries:
  - occ never exceeds 2.
  - in_valid while in FULL is ignored (no transfer).
  - out_ready while in EMPTY has no effect.
  - Reset asserted mid-stall drops all held data.

Decomposition:
- Shared package pipe_pkg holds:
  - state localparams ST_EMPTY = 2'd0, ST_MAIN = 2'd1, ST_FULL = 2'd2
  - an occ width constant OCC_W = 2
- The natural sub-module is stage_slot: a DATA_W register with load enable and synchronous clear, instantiated once for main and, under SKID_EN, once for skid.
- The KILL_BIT/CLR_BUBBLE masking is output logic in the top module.

Test Plan:
- Reset: rst = 1 for 2 cycles with in_valid = 1, in_data = 64'hDEAD -> out_valid = 0, out_data = 0, occ = 0, in_ready = 0; after release, in_ready = 1 next cycle.
- Streaming: SKID_EN = 1, out_ready = 1, push 1,2,3,4 on consecutive cycles -> out_data = 1,2,3,4 on cycles 1..4, out_valid continuous, occ = 1 throughout.
- Backpressure:
  - Stimulus: SKID_EN = 1, out_ready = 0, push 0xA then 0xB.
  - Expected while stalled: occ = 2, in_ready = 0, out_data = 0xA held stable; 0xC offered meanwhile is not accepted.
  - Expected after raising out_ready: 0xA, 0xB, then 0xC in order.
- Flush:
  - Stimulus: occ = 2 holding 0x5 and 0x6; flush = 1 with in_valid = 1, in_data = 0x7.
  - Expected: next cycle occ = 0, out_valid = 0, out_data = 0; 0x7 never appears at the output.
- Kill bit: DATA_W = 8, KILL_BIT = 0, CLR_BUBBLE = 0, output transfer of 8'hFF with no new input -> bubble out_data = 8'hFE, out_valid = 0.
- No skid: SKID_EN = 0, out_valid = 1, out_ready = 0 -> in_ready = 0 same cycle; set out_ready = 1 -> in_ready = 1 same cycle, new data on the next edge.
